// File: rtl/video_pkg.sv
// Shared types for the input-video mode classifier: published modes, FSM states and the
// per-frame {rate, passthrough} candidate.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_50   = 2'd1,
    MODE_60   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } vmd_state_t;

  typedef struct packed {
    mode_t rate;
    logic  pass;
  } cand_t;

  localparam cand_t CandNone = '{rate: MODE_NONE, pass: 1'b0};

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by an edge-detect flop; the event is registered.
// With VMD_POLARITY_DETECT_EN the active edge is chosen at run time and the level is exported.
module sync_edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
`ifdef VMD_POLARITY_DETECT_EN
  input  logic active_high_i,
  output logic level_o,
`endif
  output logic evt_o
);

  logic [2:0] sh_q;
  logic       evt_q;
  logic       rise_sel;

`ifdef VMD_POLARITY_DETECT_EN
  assign rise_sel = (active_high_i == RISING);
  assign level_o  = sh_q[1];
`else
  assign rise_sel = RISING;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_q  <= '0;
      evt_q <= 1'b0;
    end else begin
      sh_q  <= {sh_q[1:0], sync_i};
      evt_q <= rise_sel ? (sh_q[1] & ~sh_q[2]) : (~sh_q[1] & sh_q[2]);
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/video_mode_detect.sv
// Input-video classifier: measures lines and clk cycles per frame and publishes a debounced
// 50/60 Hz mode and passthrough flag. VMD_POLARITY_DETECT_EN adds sync polarity detection.
module video_mode_detect
  import video_pkg::*;
#(
  parameter int unsigned LINE_W        = 12,
  parameter int unsigned PERIOD_W      = 24,
  parameter int unsigned LINE_THRESH   = 400,
  parameter int unsigned PERIOD_SPLIT  = 2_072_727,
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned TIMEOUT       = 4_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_hsync,
  input  logic                i_vsync,
  output logic [LINE_W-1:0]   o_lines,
  output logic [PERIOD_W-1:0] o_period,
  output logic [1:0]          o_mode,
  output logic                o_passthrough,
  output logic                o_valid,
`ifdef VMD_POLARITY_DETECT_EN
  output logic                o_hs_pol,
  output logic                o_vs_pol,
`endif
  output logic                o_changed
);

  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned StW   = $clog2(STABLE_FRAMES + 1);

  logic hs_evt, vs_evt;

`ifdef VMD_POLARITY_DETECT_EN
  logic                hs_lvl, vs_lvl;
  logic                hs_pol_q, vs_pol_q;
  logic [PERIOD_W-1:0] hs_hi_q, hs_lo_q, vs_hi_q, vs_lo_q;
`endif

  sync_edge_detect #(
    .RISING (1'b1)
  ) u_hs_sync (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_i        (i_hsync),
`ifdef VMD_POLARITY_DETECT_EN
    .active_high_i (hs_pol_q),
    .level_o       (hs_lvl),
`endif
    .evt_o         (hs_evt)
  );

  sync_edge_detect #(
    .RISING (1'b1)
  ) u_vs_sync (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_i        (i_vsync),
`ifdef VMD_POLARITY_DETECT_EN
    .active_high_i (vs_pol_q),
    .level_o       (vs_lvl),
`endif
    .evt_o         (vs_evt)
  );

  vmd_state_t          state_q, state_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d, lines_q, lines_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d, period_q, period_d;
  logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [StW-1:0]      stable_q, stable_d, cnt_next;
  cand_t               cand, cand_q, cand_d, pub_q, pub_d;
  logic                changed_q, changed_d;
  logic                frame_ok, timeout, hit;

  always_comb begin
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    period_cnt_d = period_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    lines_d      = lines_q;
    period_d     = period_q;
    stable_d     = stable_q;
    cand_d       = cand_q;
    pub_d        = pub_q;
    changed_d    = 1'b0;

    // An HSYNC event coincident with VSYNC belongs to the frame that is starting.
    if (vs_evt) begin
      line_cnt_d = hs_evt ? LINE_W'(1) : '0;
    end else if (hs_evt && line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end

    if (vs_evt) begin
      period_cnt_d = PERIOD_W'(1);
      idle_cnt_d   = '0;
      lines_d      = line_cnt_q;
      period_d     = period_cnt_q;
    end else begin
      if (period_cnt_q != '1) period_cnt_d = period_cnt_q + 1'b1;
      if (idle_cnt_q != IdleW'(TIMEOUT - 1)) idle_cnt_d = idle_cnt_q + 1'b1;
    end

    cand.rate = (period_cnt_q >= PERIOD_W'(PERIOD_SPLIT)) ? MODE_50 : MODE_60;
    cand.pass = (line_cnt_q > LINE_W'(LINE_THRESH));
    frame_ok  = (period_cnt_q != '1);
    timeout   = (idle_cnt_q == IdleW'(TIMEOUT - 1)) && !vs_evt;
    cnt_next  = (stable_q != '0 && cand == cand_q) ? stable_q + StW'(1) : StW'(1);
    hit       = (cnt_next == StW'(STABLE_FRAMES));

    unique case (state_q)
      IDLE: begin
        if (vs_evt) begin
          state_d  = ACQUIRE;
          stable_d = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (timeout) begin
          state_d   = IDLE;
          pub_d     = CandNone;
          changed_d = (pub_q != CandNone);
          stable_d  = '0;
        end else if (vs_evt) begin
          if (!frame_ok) begin
            stable_d = '0;
          end else if (state_q == LOCKED && cand == pub_q) begin
            stable_d = '0;
          end else begin
            cand_d = cand;
            if (hit) begin
              pub_d     = cand;
              changed_d = (cand != pub_q);
              state_d   = LOCKED;
              stable_d  = '0;
            end else begin
              stable_d = cnt_next;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_cnt_q   <= '0;
      period_cnt_q <= '0;
      idle_cnt_q   <= '0;
      lines_q      <= '0;
      period_q     <= '0;
      stable_q     <= '0;
      cand_q       <= CandNone;
      pub_q        <= CandNone;
      changed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      period_cnt_q <= period_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      lines_q      <= lines_d;
      period_q     <= period_d;
      stable_q     <= stable_d;
      cand_q       <= cand_d;
      pub_q        <= pub_d;
      changed_q    <= changed_d;
    end
  end

`ifdef VMD_POLARITY_DETECT_EN
  // The shorter level of each sync is its active pulse; the choice applies from the next frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_pol_q <= 1'b1;
      vs_pol_q <= 1'b1;
      hs_hi_q  <= '0;
      hs_lo_q  <= '0;
      vs_hi_q  <= '0;
      vs_lo_q  <= '0;
    end else if (vs_evt) begin
      hs_pol_q <= (hs_hi_q < hs_lo_q) ? 1'b1 : (hs_hi_q > hs_lo_q) ? 1'b0 : hs_pol_q;
      vs_pol_q <= (vs_hi_q < vs_lo_q) ? 1'b1 : (vs_hi_q > vs_lo_q) ? 1'b0 : vs_pol_q;
      hs_hi_q  <= '0;
      hs_lo_q  <= '0;
      vs_hi_q  <= '0;
      vs_lo_q  <= '0;
    end else begin
      if (hs_lvl && hs_hi_q != '1) hs_hi_q <= hs_hi_q + 1'b1;
      if (!hs_lvl && hs_lo_q != '1) hs_lo_q <= hs_lo_q + 1'b1;
      if (vs_lvl && vs_hi_q != '1) vs_hi_q <= vs_hi_q + 1'b1;
      if (!vs_lvl && vs_lo_q != '1) vs_lo_q <= vs_lo_q + 1'b1;
    end
  end

  assign o_hs_pol = hs_pol_q;
  assign o_vs_pol = vs_pol_q;
`endif

  assign o_lines       = lines_q;
  assign o_period      = period_q;
  assign o_mode        = pub_q.rate;
  assign o_passthrough = pub_q.pass;
  assign o_valid       = (state_q == LOCKED);
  assign o_changed     = changed_q;

endmodule

// File: tb/tb_video_mode_detect.sv
// Bench for video_mode_detect: frame table with a latency-aligned scoreboard plus hand-written
// timeout, mid-frame reset and (with VMD_POLARITY_DETECT_EN) inverted-sync sequences.
module tb_video_mode_detect;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic [11:0] o_lines;
  logic [23:0] o_period;
  logic [1:0]  o_mode;
  logic        o_passthrough, o_valid, o_changed;
`ifdef VMD_POLARITY_DETECT_EN
  logic        o_hs_pol, o_vs_pol;
`endif

  video_mode_detect #(
    .LINE_W        (12),
    .PERIOD_W      (24),
    .LINE_THRESH   (400),
    .PERIOD_SPLIT  (1000),
    .STABLE_FRAMES (2),
    .TIMEOUT       (5000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_hsync       (i_hsync),
    .i_vsync       (i_vsync),
    .o_lines       (o_lines),
    .o_period      (o_period),
    .o_mode        (o_mode),
    .o_passthrough (o_passthrough),
    .o_valid       (o_valid),
`ifdef VMD_POLARITY_DETECT_EN
    .o_hs_pol      (o_hs_pol),
    .o_vs_pol      (o_vs_pol),
`endif
    .o_changed     (o_changed)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int period;
    int lines;
    int rst_at;
    bit chk_meas;
    int exp_lines;
    int exp_period;
    int exp_mode;
    bit exp_pass;
    bit exp_valid;
    bit exp_changed;
  } frame_t;

  typedef struct {
    int unsigned due;
    frame_t      f;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stray_changed = 0;
  bit          inv_sync = 1'b0;
  bit          sb_en = 1'b1;
  int unsigned last_vs = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t mk(int p, int n, int rst, bit cm, int el, int ep, int m, bit ps,
                                bit v, bit ch);
    frame_t f;
    f.period = p; f.lines = n; f.rst_at = rst; f.chk_meas = cm;
    f.exp_lines = el; f.exp_period = ep; f.exp_mode = m;
    f.exp_pass = ps; f.exp_valid = v; f.exp_changed = ch;
    return f;
  endfunction

  // Outputs are due 4 clock edges after the VSYNC input edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.f.chk_meas) begin
        check("sb_lines", int'(o_lines), e.f.exp_lines);
        check("sb_period", int'(o_period), e.f.exp_period);
      end
      check("sb_mode", int'(o_mode), e.f.exp_mode);
      check("sb_pass", int'(o_passthrough), int'(e.f.exp_pass));
      check("sb_valid", int'(o_valid), int'(e.f.exp_valid));
      check("sb_changed", int'(o_changed), int'(e.f.exp_changed));
    end else if (o_changed) begin
      stray_changed++;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_lines"}, int'(o_lines), 0);
    check({tag, "_period"}, int'(o_period), 0);
    check({tag, "_mode"}, int'(o_mode), 0);
    check({tag, "_pass"}, int'(o_passthrough), 0);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_changed"}, int'(o_changed), 0);
`ifdef VMD_POLARITY_DETECT_EN
    check({tag, "_hs_pol"}, int'(o_hs_pol), 1);
    check({tag, "_vs_pol"}, int'(o_vs_pol), 1);
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    i_hsync = inv_sync;
    i_vsync = inv_sync;
    @(negedge clk);
    @(negedge clk);
    check_reset(tag);
    reset_n = 1'b1;
  endtask

  task automatic run_frame(input frame_t f);
    int k = 0;
    int next_at = 0;
    for (int c = 0; c < f.period; c++) begin
      bit hs;
      @(negedge clk);
      if (f.rst_at != 0 && c == f.rst_at + 1) begin
        check_reset("midrst");
        reset_n = 1'b1;
      end
      if (f.rst_at != 0 && c == f.rst_at) reset_n = 1'b0;
      hs = (k < f.lines) && (c == next_at);
      if (hs) begin
        k++;
        next_at = (k * f.period) / f.lines;
      end
      i_hsync = hs ^ inv_sync;
      i_vsync = (c < 8) ^ inv_sync;
      if (c == 0) begin
        exp_t e;
        last_vs = cyc;
        e.due = cyc + 4;
        e.f = f;
        if (sb_en) sb.push_back(e);
      end
    end
  endtask

  task automatic idle_until(input int unsigned target);
    while (cyc < target) begin
      @(negedge clk);
      i_hsync = inv_sync;
      i_vsync = inv_sync;
    end
  endtask

  frame_t tbl_a[$];
  frame_t tbl_b[$];
  frame_t tbl_c[$];

  initial begin
    //        period lines rst meas lines period mode pass valid chg
    tbl_a.push_back(mk(1200, 300, 0, 0,   0,    0, 0, 0, 0, 0));
    tbl_a.push_back(mk(1200, 300, 0, 1, 300, 1200, 0, 0, 0, 0));
    tbl_a.push_back(mk(1200, 300, 0, 1, 300, 1200, 1, 0, 1, 1));
    tbl_a.push_back(mk( 800, 300, 0, 1, 300, 1200, 1, 0, 1, 0));
    tbl_a.push_back(mk( 800, 300, 0, 1, 300,  800, 1, 0, 1, 0));
    tbl_a.push_back(mk( 950, 450, 0, 1, 300,  800, 2, 0, 1, 1));
    tbl_a.push_back(mk( 950, 450, 0, 1, 450,  950, 2, 0, 1, 0));
    tbl_a.push_back(mk(1200, 525, 0, 1, 450,  950, 2, 1, 1, 1));
    tbl_a.push_back(mk(1200, 525, 0, 1, 525, 1200, 2, 1, 1, 0));
    tbl_a.push_back(mk(1200, 300, 0, 1, 525, 1200, 1, 1, 1, 1));
    tbl_a.push_back(mk(1200, 300, 0, 1, 300, 1200, 1, 1, 1, 0));

    tbl_b.push_back(mk(1200, 300, 0, 0,   0,    0, 0, 0, 0, 0));
    tbl_b.push_back(mk( 800, 300, 0, 1, 300, 1200, 0, 0, 0, 0));
    tbl_b.push_back(mk(1200, 300, 0, 1, 300,  800, 0, 0, 0, 0));
    tbl_b.push_back(mk( 800, 300, 0, 1, 300, 1200, 0, 0, 0, 0));
    tbl_b.push_back(mk(1200, 300, 0, 1, 300,  800, 0, 0, 0, 0));
    tbl_b.push_back(mk( 800, 300, 0, 1, 300, 1200, 0, 0, 0, 0));

    tbl_c.push_back(mk(1200, 300,   0, 0,   0,    0, 0, 0, 0, 0));
    tbl_c.push_back(mk(1200, 300,   0, 1, 300, 1200, 0, 0, 0, 0));
    tbl_c.push_back(mk(1200, 300,   0, 1, 300, 1200, 1, 0, 1, 1));
    tbl_c.push_back(mk(1200, 300, 600, 1, 300, 1200, 1, 0, 1, 0));
    tbl_c.push_back(mk(1200, 300,   0, 0,   0,    0, 0, 0, 0, 0));
    tbl_c.push_back(mk(1200, 300,   0, 1, 300, 1200, 0, 0, 0, 0));
    tbl_c.push_back(mk(1200, 300,   0, 1, 300, 1200, 1, 0, 1, 1));
    tbl_c.push_back(mk(1200, 300,   0, 1, 300, 1200, 1, 0, 1, 0));

    do_reset("init");

    // Lock, rate switch, passthrough changes; then VSYNC stops.
    foreach (tbl_a[i]) run_frame(tbl_a[i]);
    idle_until(last_vs + 4 + 4990);
    check("pre_timeout_valid", int'(o_valid), 1);
    check("pre_timeout_mode", int'(o_mode), 1);
    idle_until(last_vs + 4 + 5010);
    check("timeout_valid", int'(o_valid), 0);
    check("timeout_mode", int'(o_mode), 0);
    check("timeout_pass", int'(o_passthrough), 0);
    check("timeout_lines", int'(o_lines), 300);
    check("timeout_period", int'(o_period), 1200);

    // Alternating rates never lock.
    do_reset("rst_b");
    foreach (tbl_b[i]) run_frame(tbl_b[i]);

    // Mid-frame reset while locked, then re-lock.
    do_reset("rst_c");
    foreach (tbl_c[i]) run_frame(tbl_c[i]);

    // Only the timeout should have pulsed o_changed outside a scoreboard slot.
    check("stray_changed", stray_changed, 1);

`ifdef VMD_POLARITY_DETECT_EN
    inv_sync = 1'b1;
    sb_en = 1'b0;
    do_reset("rst_d");
    for (int i = 0; i < 6; i++) run_frame(mk(1200, 300, 0, 0, 0, 0, 0, 0, 0, 0));
    check("pol_hs", int'(o_hs_pol), 0);
    check("pol_vs", int'(o_vs_pol), 0);
    check("pol_mode", int'(o_mode), 1);
    check("pol_pass", int'(o_passthrough), 0);
    check("pol_valid", int'(o_valid), 1);
    check("pol_lines", int'(o_lines), 300);
    check("pol_period", int'(o_period), 1200);
`endif

    repeat (8) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
